// File: rtl/image_buffer_reader.sv
// +----------------------------------------------------------------------------+
// | Module      : image_buffer_reader                                          |
// | Description : Streams a rectangular window out of a frame buffer in raster |
// |               order over a read-request / pixel valid-ready pair.          |
// |               Optional start-time window bounds check: define the macro    |
// |               READER_BOUNDS_CHECK_EN to enable it.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module image_buffer_reader #(
   parameter int CAMERA_HSIZE   = 100,
   parameter int CAMERA_VSIZE   = 100,
   parameter int BUF_ADDR_WIDTH = $clog2(CAMERA_HSIZE * CAMERA_VSIZE),
   parameter int COORD_WIDTH    = 8,
   parameter int PIXEL_SIZE     = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [COORD_WIDTH-1:0]    win_x,
   input  logic [COORD_WIDTH-1:0]    win_y,
   input  logic [COORD_WIDTH-1:0]    win_w,
   input  logic [COORD_WIDTH-1:0]    win_h,
   output logic                      busy,
   output logic [BUF_ADDR_WIDTH-1:0] buf_raddr,
   output logic                      buf_rvalid,
   input  logic                      buf_rready,
   input  logic [PIXEL_SIZE-1:0]     buf_rdata,
   output logic [PIXEL_SIZE-1:0]     pix_data,
   output logic                      pix_valid,
   input  logic                      pix_ready,
   output logic                      pix_eol,
   output logic                      pix_eof,
   output logic                      err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [BUF_ADDR_WIDTH-1:0] c_hsize = BUF_ADDR_WIDTH'(CAMERA_HSIZE);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [COORD_WIDTH-1:0]    r_w;
   logic [COORD_WIDTH-1:0]    r_h;
   logic [COORD_WIDTH-1:0]    r_col;
   logic [COORD_WIDTH-1:0]    r_row;
   logic [BUF_ADDR_WIDTH-1:0] r_row_base;
   logic [BUF_ADDR_WIDTH-1:0] r_addr;
   logic [BUF_ADDR_WIDTH-1:0] w_start_base;
   logic                      w_size_ok;
   logic                      w_oob;
   logic                      w_start_ok;
   logic                      w_rd_fire;
   logic                      w_pix_fire;
   logic                      w_last_col;
   logic                      w_last_row;

   assign w_size_ok = (win_w != '0) && (win_h != '0);

`ifdef READER_BOUNDS_CHECK_EN
   logic r_err;

   assign w_oob = ((int'(win_x) + int'(win_w)) > CAMERA_HSIZE) ||
                  ((int'(win_y) + int'(win_h)) > CAMERA_VSIZE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_err <= 1'b0;
      else     r_err <= start && (r_state == ST_IDLE) && w_size_ok && w_oob;
   end

   assign err = r_err;
`else
   assign w_oob = 1'b0;
   assign err   = 1'b0;
`endif

   assign w_start_ok   = start && (r_state == ST_IDLE) && w_size_ok && !w_oob;
   // The only multiply happens once per window; per-pixel addressing is add-only.
   assign w_start_base = BUF_ADDR_WIDTH'(win_y) * c_hsize + BUF_ADDR_WIDTH'(win_x);

   // Request only when the output register is free this cycle. Once raised it
   // stays up: the register is empty (or emptying now) and only a read refills it.
   assign buf_rvalid = (r_state == ST_FETCH) && (!pix_valid || pix_ready);
   assign buf_raddr  = r_addr;
   assign busy       = (r_state != ST_IDLE);
   assign w_rd_fire  = buf_rvalid && buf_rready;
   assign w_pix_fire = pix_valid && pix_ready;
   assign w_last_col = (r_col == r_w - COORD_WIDTH'(1));
   assign w_last_row = (r_row == r_h - COORD_WIDTH'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_start_ok) w_state_nxt = ST_FETCH;
         ST_FETCH: if (w_rd_fire && w_last_col && w_last_row) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_pix_fire && pix_eof) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w        <= '0;
         r_h        <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_row_base <= '0;
         r_addr     <= '0;
      end else if (w_start_ok) begin
         r_w        <= win_w;
         r_h        <= win_h;
         r_col      <= '0;
         r_row      <= '0;
         r_row_base <= w_start_base;
         r_addr     <= w_start_base;
      end else if (w_rd_fire) begin
         if (w_last_col) begin
            r_col      <= '0;
            r_row      <= r_row + COORD_WIDTH'(1);
            r_row_base <= r_row_base + c_hsize;
            r_addr     <= r_row_base + c_hsize;
         end else begin
            r_col  <= r_col + COORD_WIDTH'(1);
            r_addr <= r_addr + BUF_ADDR_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_data  <= '0;
         pix_valid <= 1'b0;
         pix_eol   <= 1'b0;
         pix_eof   <= 1'b0;
      end else if (w_rd_fire) begin
         pix_data  <= buf_rdata;
         pix_valid <= 1'b1;
         pix_eol   <= w_last_col;
         pix_eof   <= w_last_col && w_last_row;
      end else if (w_pix_fire) begin
         pix_valid <= 1'b0;
         pix_eol   <= 1'b0;
         pix_eof   <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_image_buffer_reader.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_image_buffer_reader                                       |
// | Description : Randomized window reads checked against a raster-scan model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_image_buffer_reader;

   localparam int c_h  = 100;
   localparam int c_v  = 100;
   localparam int c_aw = 14;
   localparam int c_cw = 8;
   localparam int c_pw = 12;

   typedef struct {
      logic [c_pw-1:0] data;
      logic            eol;
      logic            eof;
   } pix_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [c_cw-1:0] win_x, win_y, win_w, win_h;
   logic            busy;
   logic [c_aw-1:0] buf_raddr;
   logic            buf_rvalid;
   logic            buf_rready;
   logic [c_pw-1:0] buf_rdata;
   logic [c_pw-1:0] pix_data;
   logic            pix_valid;
   logic            pix_ready;
   logic            pix_eol;
   logic            pix_eof;
   logic            err;

   int checks    = 0;
   int errors    = 0;
   int err_count = 0;
   int pix_count = 0;
   int rready_pct = 100;
   int pready_pct = 100;
   int stall_r = 0;
   int stall_p = 0;

   logic [c_aw-1:0] exp_addr[$];
   pix_t            exp_pix[$];

   image_buffer_reader dut (
      .clk(clk), .rst(rst), .start(start),
      .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
      .busy(busy), .buf_raddr(buf_raddr), .buf_rvalid(buf_rvalid),
      .buf_rready(buf_rready), .buf_rdata(buf_rdata),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_eol(pix_eol), .pix_eof(pix_eof), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [c_pw-1:0] mem_val(input logic [c_aw-1:0] a);
      logic [31:0] t;
      t = 32'(a) * 32'd40503 + 32'd17;
      return t[c_pw+3:4];
   endfunction

   assign buf_rdata = mem_val(buf_raddr);

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Handshake inputs change 2 time units after each rising edge
   initial begin
      buf_rready = 1'b0;
      pix_ready  = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (stall_r > 0) begin buf_rready = 1'b0; stall_r--; end
         else buf_rready = ($urandom_range(99) < rready_pct);
         if (stall_p > 0) begin pix_ready = 1'b0; stall_p--; end
         else pix_ready = ($urandom_range(99) < pready_pct);
      end
   end

   // Monitor: handshakes seen here complete at the following rising edge
   initial begin
      logic            rv_stall, pv_stall;
      logic [c_aw-1:0] p_addr;
      logic [c_pw-1:0] p_data;
      logic            p_eol, p_eof;
      pix_t            e;
      rv_stall = 1'b0;
      pv_stall = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            rv_stall = 1'b0;
            pv_stall = 1'b0;
         end else begin
            if (rv_stall) begin
               check_val("rvalid_held", 32'(buf_rvalid), 32'd1);
               check_val("raddr_held", 32'(buf_raddr), 32'(p_addr));
            end
            if (pv_stall) begin
               check_val("pix_valid_held", 32'(pix_valid), 32'd1);
               check_val("pix_data_held", 32'(pix_data), 32'(p_data));
               check_val("pix_eol_held", 32'(pix_eol), 32'(p_eol));
               check_val("pix_eof_held", 32'(pix_eof), 32'(p_eof));
            end
            if (buf_rvalid)
               check_val("rvalid_gated", 32'(!pix_valid || pix_ready), 32'd1);
            if (err) err_count++;
            if (buf_rvalid && buf_rready) begin
               check_val("read_expected", 32'(exp_addr.size() != 0), 32'd1);
               if (exp_addr.size() != 0)
                  check_val("raddr", 32'(buf_raddr), 32'(exp_addr.pop_front()));
            end
            if (pix_valid && pix_ready) begin
               pix_count++;
               check_val("pixel_expected", 32'(exp_pix.size() != 0), 32'd1);
               if (exp_pix.size() != 0) begin
                  e = exp_pix.pop_front();
                  check_val("pix_data", 32'(pix_data), 32'(e.data));
                  check_val("pix_eol", 32'(pix_eol), 32'(e.eol));
                  check_val("pix_eof", 32'(pix_eof), 32'(e.eof));
               end
            end
            rv_stall = buf_rvalid && !buf_rready;
            pv_stall = pix_valid && !pix_ready;
            p_addr   = buf_raddr;
            p_data   = pix_data;
            p_eol    = pix_eol;
            p_eof    = pix_eof;
         end
      end
   end

   // Called just after a rising edge; returns just after the next one
   task automatic start_window(input int x, input int y, input int w, input int h,
                               input bit in_flight);
      bit   acc;
      pix_t p;
      int   a;
      acc = !in_flight && (w != 0) && (h != 0);
`ifdef READER_BOUNDS_CHECK_EN
      if ((x + w > c_h) || (y + h > c_v)) acc = 1'b0;
`endif
      if (acc) begin
         for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
               a = ((y + r) * c_h + x + c) % (1 << c_aw);
               exp_addr.push_back(c_aw'(a));
               p.data = mem_val(c_aw'(a));
               p.eol  = (c == w - 1);
               p.eof  = (c == w - 1) && (r == h - 1);
               exp_pix.push_back(p);
            end
         end
      end
      win_x = c_cw'(x);
      win_y = c_cw'(y);
      win_w = c_cw'(w);
      win_h = c_cw'(h);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val("idle_in_time", 32'(n < 3000), 32'd1);
      repeat (2) begin @(posedge clk); #1; end
      check_val("reads_done", 32'(exp_addr.size()), 32'd0);
      check_val("pixels_done", 32'(exp_pix.size()), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_busy"}, 32'(busy), 32'd0);
      check_val({tag, "_rvalid"}, 32'(buf_rvalid), 32'd0);
      check_val({tag, "_raddr"}, 32'(buf_raddr), 32'd0);
      check_val({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
      check_val({tag, "_pix_data"}, 32'(pix_data), 32'd0);
      check_val({tag, "_eol"}, 32'(pix_eol), 32'd0);
      check_val({tag, "_eof"}, 32'(pix_eof), 32'd0);
      check_val({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      int n, base, e0, x, y;
      rst   = 1'b1;
      start = 1'b0;
      win_x = '0; win_y = '0; win_w = '0; win_h = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Full-rate window: one read per clock, busy spans w*h+1 cycles
      start_window(2, 3, 4, 2, 1'b0);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      check_val("busy_cycles", 32'(n), 32'd9);
      @(posedge clk); #1;
      wait_idle();

      // Downstream stall of 5 cycles mid-window
      start_window(0, 5, 4, 2, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      stall_p = 5;
      wait_idle();

      // Buffer stall of 3 cycles on the 2nd read (address 301)
      start_window(0, 3, 4, 2, 1'b0);
      @(posedge clk); #1;
      stall_r = 3;
      wait_idle();

      // Empty window, then start while busy
      start_window(5, 5, 0, 3, 1'b0);
      repeat (5) begin @(posedge clk); #1; end
      check_val("empty_not_busy", 32'(busy), 32'd0);
      start_window(1, 1, 3, 3, 1'b0);
      @(posedge clk); #1;
      start_window(10, 10, 2, 2, 1'b1);
      wait_idle();
      check_val("no_err_pulses", 32'(err_count), 32'd0);

      // Reset after the 3rd pixel, then a fresh window
      base = pix_count;
      start_window(2, 3, 4, 2, 1'b0);
      n = 0;
      while (pix_count < base + 3 && n < 200) begin @(negedge clk); n++; end
      check_val("third_pixel_seen", 32'(n < 200), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      exp_addr.delete();
      exp_pix.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      check_val("after_rst_idle", 32'(busy), 32'd0);
      start_window(6, 7, 3, 2, 1'b0);
      wait_idle();

      // Window crossing the right frame edge
      e0 = err_count;
      start_window(98, 0, 4, 1, 1'b0);
      wait_idle();
`ifdef READER_BOUNDS_CHECK_EN
      check_val("oob_err_pulse", 32'(err_count - e0), 32'd1);
`else
      check_val("oob_err_pulse", 32'(err_count - e0), 32'd0);
`endif

      // Random windows, including address wrap and random stalls
      for (int i = 0; i < 40; i++) begin
         x = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(96));
         y = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(96));
         rready_pct = int'($urandom_range(30, 100));
         pready_pct = int'($urandom_range(30, 100));
         start_window(x, y, int'($urandom_range(6)), int'($urandom_range(6)), 1'b0);
         wait_idle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/image_buffer_reader.md
IMAGE_BUFFER_READER -- requirements
Module: image_buffer_reader

Interface
REQ-001 SHALL have parameter CAMERA_HSIZE, default 100, frame width in pixels.
REQ-002 SHALL have parameter CAMERA_VSIZE, default 100, frame height in pixels.
REQ-003 SHALL have parameter BUF_ADDR_WIDTH, default ceil-log2 of CAMERA_HSIZE*CAMERA_VSIZE (14), buffer address width.
REQ-004 SHALL have parameter COORD_WIDTH, default 8, width of window coordinate and size inputs.
REQ-005 SHALL have parameter PIXEL_SIZE, default 12, pixel width.
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  input  1  one-cycle request to read a window; accepted only in IDLE.
REQ-009 SHALL have ports win_x, win_y  input  COORD_WIDTH each  window top-left column and row.
REQ-010 SHALL have ports win_w, win_h  input  COORD_WIDTH each  window width and height in pixels; 0 means empty.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port buf_raddr  output  BUF_ADDR_WIDTH  buffer read address.
REQ-013 SHALL have port buf_rvalid  output  1  read request valid.
REQ-014 SHALL have port buf_rready  input  1  buffer accepts the read; buf_rdata is valid in the same cycle.
REQ-015 SHALL have port buf_rdata  input  PIXEL_SIZE  read data.
REQ-016 SHALL have port pix_data  output  PIXEL_SIZE  streamed pixel.
REQ-017 SHALL have ports pix_valid  output  1  and pix_ready  input  1  downstream handshake; a transfer occurs when both are high at a rising edge.
REQ-018 SHALL have ports pix_eol  output  1  and pix_eof  output  1  last pixel of a window row and last pixel of the window, qualified by pix_valid.
REQ-019 SHALL have port err  output  1  one-cycle pulse on a rejected start.

Function
REQ-020 SHALL implement FSM IDLE -> FETCH -> DRAIN -> IDLE.
REQ-021 IDLE: start with win_w!=0 and win_h!=0 SHALL latch all window inputs and go to FETCH; start with either size equal to 0 SHALL stay in IDLE with no reads.
REQ-022 Address SHALL be (win_y+row)*CAMERA_HSIZE + win_x + col, computed incrementally (row base plus CAMERA_HSIZE per row), with no multiplier in the per-pixel path.
REQ-023 Scan order SHALL be raster: col 0..win_w-1 within each row, then row 0..win_h-1.
REQ-024 FETCH: buf_rvalid SHALL be high only when the output register is empty or is being drained in the same cycle.
REQ-025 Once asserted, buf_rvalid and buf_raddr SHALL be held stable until buf_rready.
REQ-026 On buf_rvalid&&buf_rready, buf_rdata SHALL be registered into pix_data, pix_valid set the next cycle, and col/row advanced (latency 1 cycle, request to pix_valid).
REQ-027 pix_data, pix_eol, and pix_eof SHALL be held stable while pix_valid&&!pix_ready.
REQ-028 Sustained throughput SHALL be 1 pixel/clk when buf_rready and pix_ready are held high.
REQ-029 Accepting the last read (col=win_w-1, row=win_h-1) SHALL move FETCH to DRAIN; DRAIN SHALL return to IDLE on the pix_eof transfer.
REQ-030 start while busy SHALL be ignored without an err pulse.
REQ-031 Address arithmetic SHALL wrap modulo 2^BUF_ADDR_WIDTH.

Reset
REQ-032 rst SHALL immediately force state IDLE, and set buf_rvalid, pix_valid, pix_eol, pix_eof, err, busy = 0 and buf_raddr, pix_data = 0.
REQ-033 rst mid-window SHALL abandon the window, with no further reads or pixels; the next start SHALL begin a fresh window.

Configuration
REQ-034 With READER_BOUNDS_CHECK_EN defined, start with win_x+win_w>CAMERA_HSIZE or win_y+win_h>CAMERA_VSIZE SHALL be rejected: state stays IDLE, err pulses 1 cycle, no reads.
REQ-035 Without READER_BOUNDS_CHECK_EN, err SHALL be tied to 0 and out-of-range windows SHALL be read with addresses per REQ-022/REQ-031.

Verification
REQ-036 Window x=2, y=3, w=4, h=2, with buf_rready and pix_ready held high -> addresses 302..305 then 402..405 on consecutive cycles; 8 pixels; pix_eol on pixels 4 and 8; pix_eof on pixel 8; busy falls after it.
REQ-037 pix_ready low for 5 cycles mid-window -> pix_data held, at most 1 outstanding read, no pixel lost or duplicated.
REQ-038 buf_rready delayed 3 cycles on the 2nd read -> buf_raddr held at 301 for 3 cycles, pixel order intact.
REQ-039 start with w=0, or start while busy -> no buf_rvalid and no err; the in-flight window is unaffected.
REQ-040 rst pulse after the 3rd pixel of a 4x2 window, then a new start -> all outputs 0 immediately; the new window reads from its first address.
REQ-041 With READER_BOUNDS_CHECK_EN, x=98, w=4 -> err pulse, no reads; without the macro, the same start -> 4 reads at addresses 98..101.
